gen_step_sequencer: RTL and testbench
=====================================

GEN_STEP_SEQUENCER -- requirements
Module: gen_step_sequencer

Interface
REQ-001 SHALL have parameter TEMPO_W, default 24, giving the width of tempo_div and the internal divider counter.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port run, input, 1 bit: level; 1 = sequencer running.
REQ-005 SHALL have port tempo_div, input, TEMPO_W bits: clk cycles per step; 0 is treated as 1.
REQ-006 SHALL have port step_len, input, 3 bits: steps per pattern minus 1 (1..8 steps).
REQ-007 SHALL have port density, input, 4 bits: trigger probability threshold.
REQ-008 SHALL have port note_base, input, 7 bits: base note number.
REQ-009 SHALL have port seed, input, 16 bits: LFSR seed value.
REQ-010 SHALL have port seed_load, input, 1 bit: 1-cycle strobe that loads seed.
REQ-011 SHALL have port step_idx, output, 3 bits: current step index.
REQ-012 SHALL have port note, output, 7 bits: note of the most recent trigger.
REQ-013 SHALL have port note_valid, output, 1 bit: 1-cycle strobe on each trigger.
REQ-014 SHALL have port gate, output, 1 bit: note gate.
REQ-015 SHALL have port busy, output, 1 bit: 1 while in state RUN.
REQ-016 SHALL have port lfsr_state, output, 16 bits: current LFSR register.

Function
REQ-017 SHALL implement two states, IDLE and RUN; IDLE->RUN on an edge with run=1; RUN->IDLE on an edge with run=0.
REQ-018 SHALL define tempo_eff = (tempo_div==0) ? 1 : tempo_div and gate_len = max(1, tempo_eff>>1), both evaluated combinationally every cycle.
REQ-019 SHALL produce a step event on an edge where (IDLE and run=1) or (RUN and run=1 and div_cnt >= tempo_eff-1); using >= means a tempo decrease below div_cnt fires the step immediately instead of wrapping.
REQ-020 SHALL, in RUN with run=1 and no step event, increment div_cnt by 1; at a step event, set div_cnt to 0.
REQ-021 SHALL implement the LFSR as a 16-bit Galois right-shift: next = lsb ? (s>>1) ^ 16'hB400 : (s>>1).
REQ-022 SHALL, at a step event, advance the LFSR once and take rnd = the advanced value.
REQ-023 SHALL advance the LFSR at step events only, whether or not a trigger occurs.
REQ-024 SHALL trigger at a step event when rnd[3:0] < density; density=0 therefore never triggers and density=15 triggers 15/16 of the time.
REQ-025 SHALL, on a trigger, register note = min(127, note_base + rnd[7:4]), computed 8 bits wide and saturated; note holds its value otherwise.
REQ-026 SHALL, at a step event, set note_valid = trigger and gate = trigger; note_valid SHALL be 0 on every other edge.
REQ-027 SHALL, when no step event occurs in RUN, set gate = gate && (div_cnt+1 < gate_len), so gate is high for exactly gate_len cycles after a trigger.
REQ-028 SHALL set step_idx to 0 on the first step event after IDLE.
REQ-029 SHALL, on later step events, set step_idx to 0 if step_idx >= step_len, else step_idx+1.
REQ-030 SHALL treat a step_len change mid-run as taking effect on the next step event.
REQ-031 SHALL, on a run=0 edge in RUN, go to IDLE with gate=0, note_valid=0, div_cnt=0, and hold step_idx, note and LFSR.
REQ-032 SHALL, on seed_load=1, load the LFSR with seed, or with 16'hACE1 if seed==0; seed_load overrides any step-event advance on the same edge, while that step's trigger and note still use the rnd from the pre-load value.
REQ-033 SHALL keep the LFSR non-zero at all times.

Reset
REQ-034 SHALL, on an edge with reset=1, set state=IDLE, div_cnt=0, step_idx=0, note=0, note_valid=0, gate=0, busy=0, lfsr_state=16'hACE1; reset overrides run and seed_load.
REQ-035 SHALL allow reset asserted mid-step to abort the step, with the full reset state visible after that edge.

Verification
REQ-036 SHALL cover: reset held 2 cycles -> all outputs 0 and lfsr_state=0xACE1.
REQ-037 SHALL cover: tempo_div=4, density=15, note_base=60, step_len=7, run 0->1.
- Next edge: note_valid=1, note=67, gate high 2 cycles, step_idx=0, lfsr_state=0xE270.
- 4 edges later: lfsr_state=0x7138, note=63, step_idx=1.
REQ-038 SHALL cover: step_len=1, density=0, run=1 -> step_idx sequence 0,1,0,1; note_valid and gate never 1; LFSR still advances each step.
REQ-039 SHALL cover: density=8 at second step (rnd[3:0]=8) -> no trigger; density=9 -> trigger with note=base+3.
REQ-040 SHALL cover: seed_load with seed=0, then note_base=125 -> lfsr_state=0xACE1, first note saturates to 127.
REQ-041 SHALL cover: tempo_div changed 100->2 while div_cnt=50 -> step event on the next edge; reset mid-gate -> gate=0 and busy=0 after that edge.

Source files
------------

// File: rtl/gen_step_sequencer.sv
// Generative step sequencer: tempo divider, LFSR-driven probabilistic triggers,
// saturated note generation and a gate of roughly half a step.
module gen_step_sequencer #(
  parameter int TEMPO_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [2:0]         step_len,
  input  logic [3:0]         density,
  input  logic [6:0]         note_base,
  input  logic [15:0]        seed,
  input  logic               seed_load,
  output logic [2:0]         step_idx,
  output logic [6:0]         note,
  output logic               note_valid,
  output logic               gate,
  output logic               busy,
  output logic [15:0]        lfsr_state
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  state_t             state_reg, state_next;
  logic [TEMPO_W-1:0] div_cnt_reg, div_cnt_next;
  logic [2:0]         step_idx_reg, step_idx_next;
  logic [6:0]         note_reg, note_next;
  logic               note_valid_reg, note_valid_next;
  logic               gate_reg, gate_next;
  logic [15:0]        lfsr_reg, lfsr_next;

  logic [TEMPO_W-1:0] tempo_eff;
  logic [TEMPO_W-1:0] gate_len;
  logic               step_event;
  logic [15:0]        lfsr_adv;
  logic               trigger;
  logic [7:0]         note_sum;
  logic [6:0]         note_sat;
  logic               gate_hold;

  always_comb begin
    tempo_eff  = (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
    gate_len   = ((tempo_eff >> 1) == '0) ? TEMPO_W'(1) : (tempo_eff >> 1);
    // >= rather than == so a tempo drop below the running count steps at once
    step_event = run && ((state_reg == IDLE) || (div_cnt_reg >= (tempo_eff - TEMPO_W'(1))));
    lfsr_adv   = lfsr_reg[0] ? ((lfsr_reg >> 1) ^ LFSR_TAPS) : (lfsr_reg >> 1);
    trigger    = step_event && (lfsr_adv[3:0] < density);
    note_sum   = {1'b0, note_base} + {4'b0000, lfsr_adv[7:4]};
    note_sat   = (note_sum > 8'd127) ? 7'd127 : note_sum[6:0];
    gate_hold  = (({1'b0, div_cnt_reg}) + (TEMPO_W + 1)'(1)) < {1'b0, gate_len};
  end

  always_comb begin
    state_next      = state_reg;
    div_cnt_next    = div_cnt_reg;
    step_idx_next   = step_idx_reg;
    note_next       = note_reg;
    note_valid_next = 1'b0;
    gate_next       = gate_reg;
    lfsr_next       = lfsr_reg;

    if (step_event) begin
      state_next      = RUN;
      div_cnt_next    = '0;
      lfsr_next       = lfsr_adv;
      note_valid_next = trigger;
      gate_next       = trigger;
      if (trigger)
        note_next = note_sat;
      if (state_reg == IDLE || step_idx_reg >= step_len)
        step_idx_next = 3'd0;
      else
        step_idx_next = step_idx_reg + 3'd1;
    end else if (state_reg == RUN) begin
      if (run) begin
        div_cnt_next = div_cnt_reg + TEMPO_W'(1);
        gate_next    = gate_reg && gate_hold;
      end else begin
        state_next   = IDLE;
        div_cnt_next = '0;
        gate_next    = 1'b0;
      end
    end

    // The trigger above already used the pre-load value; only the register is replaced
    if (seed_load)
      lfsr_next = (seed == 16'h0000) ? LFSR_INIT : seed;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      div_cnt_reg    <= '0;
      step_idx_reg   <= 3'd0;
      note_reg       <= 7'd0;
      note_valid_reg <= 1'b0;
      gate_reg       <= 1'b0;
      lfsr_reg       <= LFSR_INIT;
    end else begin
      state_reg      <= state_next;
      div_cnt_reg    <= div_cnt_next;
      step_idx_reg   <= step_idx_next;
      note_reg       <= note_next;
      note_valid_reg <= note_valid_next;
      gate_reg       <= gate_next;
      lfsr_reg       <= lfsr_next;
    end
  end

  assign step_idx   = step_idx_reg;
  assign note       = note_reg;
  assign note_valid = note_valid_reg;
  assign gate       = gate_reg;
  assign busy       = (state_reg == RUN);
  assign lfsr_state = lfsr_reg;

endmodule

// File: tb/tb_gen_step_sequencer.sv
// Directed bench for gen_step_sequencer; triggered notes go through an expected-note queue.
module tb_gen_step_sequencer;

  localparam int TEMPO_W = 24;

  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic [TEMPO_W-1:0] tempo_div;
  logic [2:0]         step_len;
  logic [3:0]         density;
  logic [6:0]         note_base;
  logic [15:0]        seed;
  logic               seed_load;
  logic [2:0]         step_idx;
  logic [6:0]         note;
  logic               note_valid;
  logic               gate;
  logic               busy;
  logic [15:0]        lfsr_state;

  int n_cmp = 0;
  int n_bad = 0;
  logic [6:0]  exp_q[$];
  logic [6:0]  exp_note;
  logic [15:0] m_lfsr;
  logic        seen;

  gen_step_sequencer #(.TEMPO_W(TEMPO_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .tempo_div  (tempo_div),
    .step_len   (step_len),
    .density    (density),
    .note_base  (note_base),
    .seed       (seed),
    .seed_load  (seed_load),
    .step_idx   (step_idx),
    .note       (note),
    .note_valid (note_valid),
    .gate       (gate),
    .busy       (busy),
    .lfsr_state (lfsr_state)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_f(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then let the scoreboard consume any note the DUT emitted
  task automatic tick();
    @(posedge clk);
    #1;
    if (note_valid === 1'b1) begin
      chk("sb_expected_present", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
      if (exp_q.size() > 0) begin
        exp_note = exp_q.pop_front();
        chk("sb_note", {25'd0, note}, {25'd0, exp_note});
      end
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; tempo_div = 24'd4; step_len = 3'd7; density = 4'd15;
    note_base = 7'd60; seed = 16'h0000; seed_load = 1'b0;
    tick();
    tick();
    chk("rst_step_idx", step_idx, 0);
    chk("rst_note", note, 0);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_gate", gate, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lfsr", lfsr_state, 32'hACE1);

    // First step straight out of IDLE, then a 4-cycle step period
    reset = 1'b0; run = 1'b1; exp_q.push_back(7'd67);
    tick();
    chk("s1_valid", note_valid, 1);
    chk("s1_step_idx", step_idx, 0);
    chk("s1_lfsr", lfsr_state, 32'hE270);
    chk("s1_gate", gate, 1);
    chk("s1_busy", busy, 1);
    tick();
    chk("s1_gate_c2", gate, 1);
    chk("s1_valid_c2", note_valid, 0);
    tick();
    chk("s1_gate_c3", gate, 0);
    tick();
    chk("s1_lfsr_hold", lfsr_state, 32'hE270);
    exp_q.push_back(7'd63);
    tick();
    chk("s2_lfsr", lfsr_state, 32'h7138);
    chk("s2_step_idx", step_idx, 1);

    // Stop: state returns to IDLE, step/note/LFSR held
    run = 1'b0;
    tick();
    chk("stop_busy", busy, 0);
    chk("stop_gate", gate, 0);
    chk("stop_step_idx", step_idx, 1);
    chk("stop_note", note, 63);
    chk("stop_lfsr", lfsr_state, 32'h7138);

    // Density threshold at rnd[3:0]=8
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b1; tempo_div = 24'd1; density = 4'd15; note_base = 7'd60;
    exp_q.push_back(7'd67);
    tick();
    density = 4'd8;
    tick();
    chk("d8_valid", note_valid, 0);
    chk("d8_gate", gate, 0);
    chk("d8_lfsr", lfsr_state, 32'h7138);
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0; run = 1'b1; density = 4'd15; exp_q.push_back(7'd67);
    tick();
    density = 4'd9; exp_q.push_back(7'd63);
    tick();
    chk("d9_valid", note_valid, 1);

    // Two-step pattern with density 0: no triggers but LFSR keeps stepping
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0; run = 1'b1; step_len = 3'd1; density = 4'd0; m_lfsr = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      tick();
      m_lfsr = lfsr_f(m_lfsr);
      chk("len2_step_idx", step_idx, i % 2);
      chk("len2_lfsr", lfsr_state, m_lfsr);
      chk("len2_valid", note_valid, 0);
      chk("len2_gate", gate, 0);
    end

    // Zero seed maps to ACE1; saturation; seed_load on a step edge
    run = 1'b0; seed = 16'h0000; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    chk("seed0_lfsr", lfsr_state, 32'hACE1);
    chk("seed0_busy", busy, 0);
    note_base = 7'd125; density = 4'd15; run = 1'b1; exp_q.push_back(7'd127);
    tick();
    chk("sat_lfsr", lfsr_state, 32'hE270);
    note_base = 7'd10; seed = 16'h1234; seed_load = 1'b1; exp_q.push_back(7'd13);
    tick();
    seed_load = 1'b0;
    chk("load_step_lfsr", lfsr_state, 32'h1234);

    // Tempo drop below the running count, then reset in the middle of a gate
    reset = 1'b1; run = 1'b0;
    tick();
    reset = 1'b0; tempo_div = 24'd100; density = 4'd0; step_len = 3'd7; run = 1'b1;
    tick();
    repeat (50) tick();
    chk("slow_step_idx", step_idx, 0);
    chk("slow_lfsr", lfsr_state, 32'hE270);
    tempo_div = 24'd2;
    tick();
    chk("drop_step_idx", step_idx, 1);
    chk("drop_lfsr", lfsr_state, 32'h7138);
    tempo_div = 24'd8; density = 4'd15; note_base = 7'd60; exp_q.push_back(7'd69);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      seen = (note_valid === 1'b1);
    end
    chk("t8_trigger_seen", seen, 1);
    tick();
    chk("t8_gate_mid", gate, 1);
    reset = 1'b1;
    tick();
    chk("abort_gate", gate, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", note_valid, 0);
    chk("abort_step_idx", step_idx, 0);
    chk("abort_note", note, 0);
    chk("abort_lfsr", lfsr_state, 32'hACE1);

    chk("sb_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
